systolic_pe_acc: RTL and testbench

SYSTOLIC_PE_ACC -- requirements
Module: systolic_pe_acc

---
 rtl/systolic_pe_acc_if.sv | 40 ++++
 rtl/systolic_pe_acc.sv | 126 ++++++++++++
 tb/tb_systolic_pe_acc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pe_acc_if.sv
// Operand, forwarding and result-drain signals of one systolic MAC processing element.
// Signal names carry the PE's own direction suffix; the master modport is the PE's surroundings.
interface systolic_pe_acc_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic [DATA_W-1:0] top_i;
  logic              top_valid_i;
  logic [DATA_W-1:0] left_i;
  logic              left_valid_i;
  logic              left_last_i;
  logic [DATA_W-1:0] down_o;
  logic              down_valid_o;
  logic [DATA_W-1:0] right_o;
  logic              right_valid_o;
  logic              right_last_o;
  logic [ACC_W-1:0]  acc_o;
  logic [ACC_W-1:0]  res_i;
  logic              res_valid_i;
  logic              res_ready_o;
  logic [ACC_W-1:0]  res_o;
  logic              res_sat_o;
  logic              res_valid_o;
  logic              res_ready_i;
  logic              err_o;

  modport slave (
    input  top_i, top_valid_i, left_i, left_valid_i, left_last_i,
    input  res_i, res_valid_i, res_ready_i,
    output down_o, down_valid_o, right_o, right_valid_o, right_last_o,
    output acc_o, res_ready_o, res_o, res_sat_o, res_valid_o, err_o
  );

  modport master (
    output top_i, top_valid_i, left_i, left_valid_i, left_last_i,
    output res_i, res_valid_i, res_ready_i,
    input  down_o, down_valid_o, right_o, right_valid_o, right_last_o,
    input  acc_o, res_ready_o, res_o, res_sat_o, res_valid_o, err_o
  );
endinterface

// File: rtl/systolic_pe_acc.sv
// Systolic-array PE: forwards operands, accumulates top*left per tile, and drains
// closed-tile results through a shared result chain with priority over upstream results.
module systolic_pe_acc #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  systolic_pe_acc_if.slave io
);

  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [DATA_W-1:0]   down_q, right_q;
  logic                down_valid_q, right_valid_q, right_last_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                sat_q, sat_d;
  logic [ACC_W-1:0]    own_q;
  logic                own_sat_q, own_valid_q;
  logic [ACC_W-1:0]    out_q;
  logic                out_sat_q, out_valid_q;
  logic                err_q;

  logic [2*DATA_W-1:0] top_x, left_x, prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      sum_w;
  logic                ovf;
  logic                mac_fire, tile_close, out_free, own_drain;

  assign mac_fire   = io.top_valid_i & io.left_valid_i;
  assign tile_close = mac_fire & io.left_last_i;
  assign out_free   = ~out_valid_q | io.res_ready_i;
  assign own_drain  = out_free & own_valid_q;

  // Operands are widened before multiplying so the low 2*DATA_W bits are exact for either signedness.
  always_comb begin
    top_x    = SIGNED ? (2*DATA_W)'($signed(io.top_i))  : (2*DATA_W)'(io.top_i);
    left_x   = SIGNED ? (2*DATA_W)'($signed(io.left_i)) : (2*DATA_W)'(io.left_i);
    prod     = top_x * left_x;
    prod_ext = SIGNED ? ACC_W'($signed(prod)) : ACC_W'(prod);
    sum_w    = {1'b0, acc_q} + {1'b0, prod_ext};
    if (SIGNED)
      ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf = sum_w[ACC_W];
    acc_d = sum_w[ACC_W-1:0];
    sat_d = sat_q;
    if (SATURATE && ovf) begin
      sat_d = 1'b1;
      if (SIGNED) acc_d = acc_q[ACC_W-1] ? S_MIN : S_MAX;
      else        acc_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_q        <= '0;
      down_valid_q  <= 1'b0;
      right_q       <= '0;
      right_valid_q <= 1'b0;
      right_last_q  <= 1'b0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      own_q         <= '0;
      own_sat_q     <= 1'b0;
      own_valid_q   <= 1'b0;
      out_q         <= '0;
      out_sat_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      down_q        <= io.top_i;
      down_valid_q  <= io.top_valid_i;
      right_q       <= io.left_i;
      right_valid_q <= io.left_valid_i;
      right_last_q  <= io.left_last_i;

      if (mac_fire) begin
        acc_q <= tile_close ? '0 : acc_d;
        sat_q <= tile_close ? 1'b0 : sat_d;
      end

      // The own slot accepts a new result when empty or when its old one drains this edge.
      if (tile_close && (!own_valid_q || own_drain)) begin
        own_q       <= acc_d;
        own_sat_q   <= sat_d;
        own_valid_q <= 1'b1;
      end else if (own_drain) begin
        own_valid_q <= 1'b0;
      end

      if (out_free) begin
        if (own_valid_q) begin
          out_q       <= own_q;
          out_sat_q   <= own_sat_q;
          out_valid_q <= 1'b1;
        end else if (io.res_valid_i) begin
          out_q       <= io.res_i;
          out_sat_q   <= 1'b0;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end

      if ((io.top_valid_i ^ io.left_valid_i) || (tile_close && own_valid_q && !own_drain))
        err_q <= 1'b1;
    end
  end

  assign io.down_o        = down_q;
  assign io.down_valid_o  = down_valid_q;
  assign io.right_o       = right_q;
  assign io.right_valid_o = right_valid_q;
  assign io.right_last_o  = right_last_q;
  assign io.acc_o         = acc_q;
  assign io.res_o         = out_q;
  assign io.res_sat_o     = out_sat_q;
  assign io.res_valid_o   = out_valid_q;
  assign io.res_ready_o   = out_free & ~own_valid_q;
  assign io.err_o         = err_q;

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Directed bench for systolic_pe_acc: default 16/40 instance plus 8/16 saturating and wrapping instances.
module tb_systolic_pe_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  systolic_pe_acc_if #(.DATA_W(16), .ACC_W(40)) io ();
  systolic_pe_acc_if #(.DATA_W(8),  .ACC_W(16)) io_s ();
  systolic_pe_acc_if #(.DATA_W(8),  .ACC_W(16)) io_w ();

  systolic_pe_acc #(.DATA_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b1))
    dut (.clk(clk), .rst(rst), .io(io));
  systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1))
    dut_s (.clk(clk), .rst(rst), .io(io_s));
  systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0))
    dut_w (.clk(clk), .rst(rst), .io(io_w));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tv, input logic [15:0] t, input logic lv,
                       input logic [15:0] l, input logic last);
    io.top_valid_i  = tv;
    io.top_i        = t;
    io.left_valid_i = lv;
    io.left_i       = l;
    io.left_last_i  = last;
  endtask

  task automatic drive8(input logic v, input logic [7:0] t, input logic [7:0] l, input logic last);
    io_s.top_valid_i = v;  io_w.top_valid_i = v;
    io_s.left_valid_i = v; io_w.left_valid_i = v;
    io_s.top_i = t;        io_w.top_i = t;
    io_s.left_i = l;       io_w.left_i = l;
    io_s.left_last_i = last; io_w.left_last_i = last;
  endtask

  task automatic idle();
    drive(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    io.res_i = '0;   io.res_valid_i = 1'b0;   io.res_ready_i = 1'b1;
    drive8(1'b0, 8'd0, 8'd0, 1'b0);
    io_s.res_i = '0; io_s.res_valid_i = 1'b0; io_s.res_ready_i = 1'b1;
    io_w.res_i = '0; io_w.res_valid_i = 1'b0; io_w.res_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_acc",       64'(io.acc_o), 64'd0);
    check("rst_res_valid", 64'(io.res_valid_o), 64'd0);
    check("rst_err",       64'(io.err_o), 64'd0);
    check("rst_ready",     64'(io.res_ready_o), 64'd1);
    check("rst_down_valid", 64'(io.down_valid_o), 64'd0);

    // forwarding is unconditional; last without a MAC is ignored
    drive(1'b0, 16'h1234, 1'b0, 16'h00AB, 1'b1);
    tick();
    check("fwd_down",       64'(io.down_o), 64'h1234);
    check("fwd_right",      64'(io.right_o), 64'h00AB);
    check("fwd_right_last", 64'(io.right_last_o), 64'd1);
    check("fwd_down_valid", 64'(io.down_valid_o), 64'd0);
    check("fwd_no_err",     64'(io.err_o), 64'd0);
    check("fwd_no_res",     64'(io.res_valid_o), 64'd0);

    // 4-element tile: 1*5+2*6+3*7+4*8 = 70
    drive(1'b1, 16'd5, 1'b1, 16'd1, 1'b0); tick(); check("t4_acc1", 64'(io.acc_o), 64'd5);
    drive(1'b1, 16'd6, 1'b1, 16'd2, 1'b0); tick(); check("t4_acc2", 64'(io.acc_o), 64'd17);
    drive(1'b1, 16'd7, 1'b1, 16'd3, 1'b0); tick(); check("t4_acc3", 64'(io.acc_o), 64'd38);
    drive(1'b1, 16'd8, 1'b1, 16'd4, 1'b1); tick();
    check("t4_acc_clear", 64'(io.acc_o), 64'd0);
    check("t4_down_valid", 64'(io.down_valid_o), 64'd1);
    check("t4_right_last", 64'(io.right_last_o), 64'd1);
    idle(); tick();
    check("t4_res",       64'(io.res_o), 64'd70);
    check("t4_res_valid", 64'(io.res_valid_o), 64'd1);
    check("t4_res_sat",   64'(io.res_sat_o), 64'd0);
    tick();
    check("t4_res_once",  64'(io.res_valid_o), 64'd0);

    // upstream result passes through with sat=0
    io.res_i = 40'd123; io.res_valid_i = 1'b1;
    check("up_ready", 64'(io.res_ready_o), 64'd1);
    tick();
    check("up_res",       64'(io.res_o), 64'd123);
    check("up_res_valid", 64'(io.res_valid_o), 64'd1);
    io.res_valid_i = 1'b0;
    tick();
    check("up_res_done",  64'(io.res_valid_o), 64'd0);

    // back-to-back single-element tiles 10 then 20
    drive(1'b1, 16'd5, 1'b1, 16'd2, 1'b1); tick();
    drive(1'b1, 16'd5, 1'b1, 16'd4, 1'b1); tick();
    idle();
    check("b2b_first", 64'(io.res_o), 64'd10);
    check("b2b_first_valid", 64'(io.res_valid_o), 64'd1);
    tick();
    check("b2b_second", 64'(io.res_o), 64'd20);
    check("b2b_err",    64'(io.err_o), 64'd0);
    tick();
    check("b2b_done",   64'(io.res_valid_o), 64'd0);

    // one-sided valid: no MAC, sticky error
    drive(1'b1, 16'd3, 1'b1, 16'd3, 1'b0); tick();
    check("err_acc_pre", 64'(io.acc_o), 64'd9);
    drive(1'b1, 16'd7, 1'b0, 16'd7, 1'b1); tick();
    check("err_acc_hold", 64'(io.acc_o), 64'd9);
    check("err_set",      64'(io.err_o), 64'd1);
    idle(); tick(); tick();
    check("err_sticky",   64'(io.err_o), 64'd1);
    check("err_no_res",   64'(io.res_valid_o), 64'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("err_rst_clear", 64'(io.err_o), 64'd0);
    check("err_rst_acc",   64'(io.acc_o), 64'd0);

    // reset mid-tile discards the partial sum
    drive(1'b1, 16'd2, 1'b1, 16'd2, 1'b0); tick();
    drive(1'b1, 16'd2, 1'b1, 16'd2, 1'b0); tick();
    check("mid_acc", 64'(io.acc_o), 64'd8);
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_acc", 64'(io.acc_o), 64'd0);
    drive(1'b1, 16'd3, 1'b1, 16'd3, 1'b1); tick();
    idle(); tick();
    check("mid_res",       64'(io.res_o), 64'd9);
    check("mid_res_valid", 64'(io.res_valid_o), 64'd1);
    tick();

    // backpressure: local results win over upstream, overflowing close sets err
    io.res_ready_i = 1'b0;
    drive(1'b1, 16'd3, 1'b1, 16'd2, 1'b1); tick();
    idle(); tick();
    io.res_i = 40'd555; io.res_valid_i = 1'b1;
    check("bp_res_a",     64'(io.res_o), 64'd6);
    check("bp_res_valid", 64'(io.res_valid_o), 64'd1);
    check("bp_ready_low", 64'(io.res_ready_o), 64'd0);
    drive(1'b1, 16'd7, 1'b1, 16'd1, 1'b1); tick();
    check("bp_hold_a",  64'(io.res_o), 64'd6);
    check("bp_no_err",  64'(io.err_o), 64'd0);
    drive(1'b1, 16'd1, 1'b1, 16'd1, 1'b1); tick();
    idle();
    check("bp_drop_err", 64'(io.err_o), 64'd1);
    check("bp_hold_a2",  64'(io.res_o), 64'd6);
    check("bp_acc_clear", 64'(io.acc_o), 64'd0);
    io.res_ready_i = 1'b1;
    check("bp_ready_own_full", 64'(io.res_ready_o), 64'd0);
    tick();
    check("bp_res_b",    64'(io.res_o), 64'd7);
    check("bp_ready_up", 64'(io.res_ready_o), 64'd1);
    tick();
    check("bp_res_up",     64'(io.res_o), 64'd555);
    check("bp_res_up_sat", 64'(io.res_sat_o), 64'd0);
    io.res_valid_i = 1'b0;
    tick();
    check("bp_done", 64'(io.res_valid_o), 64'd0);

    // 8/16 signed: three -128*-128 products saturate vs wrap
    drive8(1'b1, 8'h80, 8'h80, 1'b0); tick();
    check("sat_acc1", 64'(io_s.acc_o), 64'h4000);
    drive8(1'b1, 8'h80, 8'h80, 1'b0); tick();
    check("sat_acc2",  64'(io_s.acc_o), 64'h7FFF);
    check("wrap_acc2", 64'(io_w.acc_o), 64'h8000);
    drive8(1'b1, 8'h80, 8'h80, 1'b1); tick();
    drive8(1'b0, 8'h00, 8'h00, 1'b0); tick();
    check("sat_res",      64'(io_s.res_o), 64'h7FFF);
    check("sat_res_flag", 64'(io_s.res_sat_o), 64'd1);
    check("sat_valid",    64'(io_s.res_valid_o), 64'd1);
    check("wrap_res",      64'(io_w.res_o), 64'hC000);
    check("wrap_res_flag", 64'(io_w.res_sat_o), 64'd0);
    check("sat_acc_clear", 64'(io_s.acc_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
